// File: rtl/pvr_tile_pkg.sv
// Shared tile geometry and capture-sequencer state encodings for the PVR tile path.
package pvr_tile_pkg;

  localparam int unsigned TILE_DIM   = 32;
  localparam int unsigned LANE_W     = 32;
  localparam int unsigned COORD_W    = 11;
  localparam int unsigned TILE_IDX_W = 6;
  localparam int unsigned ROW_IDX_W  = $clog2(TILE_DIM);
  localparam int unsigned ROW_BITS   = TILE_DIM * LANE_W;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_SETTLE  = 2'd1,
    CAP_CAPTURE = 2'd2,
    CAP_WAITBUF = 2'd3
  } cap_state_t;

endpackage

// File: rtl/tile_row_buf.sv
// Two-entry ping-pong row buffer: one full row written at once, read one lane at a time.
module tile_row_buf
  import pvr_tile_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_sel,
  input  logic                 wr_en,
  input  logic [ROW_BITS-1:0]  wr_data,
  input  logic                 rd_sel,
  input  logic [ROW_IDX_W-1:0] rd_col,
  output logic [LANE_W-1:0]    rd_data,
  input  logic                 free,
  output logic [1:0]           full
);

  logic [ROW_BITS-1:0] row_mem [2];

  // Row storage; cleared on reset so the read port shows zero after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        row_mem[i] <= '0;
      end
    end else if (wr_en) begin
      row_mem[wr_sel] <= wr_data;
    end
  end

  // Full flags: set by a row write, cleared by a free pulse on the read-side entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (wr_en && (wr_sel == 1'(i))) begin
          full[i] <= 1'b1;
        end else if (free && (rd_sel == 1'(i))) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  // Lane select of the entry being streamed.
  always_comb begin
    rd_data = row_mem[rd_sel][rd_col*LANE_W +: LANE_W];
  end

endmodule

// File: rtl/tile_row_stepper.sv
// Steps interpolator Y through a 32x32 tile, captures each row of lanes into a
// ping-pong buffer and streams the pixels out in raster order.
module tile_row_stepper
  import pvr_tile_pkg::*;
#(
  parameter int unsigned SETTLE = 2
)
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [TILE_IDX_W-1:0] tile_x,
  input  logic [TILE_IDX_W-1:0] tile_y,
  output logic [COORD_W-1:0]    x_ps,
  output logic [COORD_W-1:0]    y_ps,
  input  logic [ROW_BITS-1:0]   lanes_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANE_W-1:0]     out_data,
  output logic [ROW_IDX_W-1:0]  out_x,
  output logic [ROW_IDX_W-1:0]  out_y,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ROW_IDX_W-1:0] ROW_LAST = ROW_IDX_W'(TILE_DIM - 1);
  localparam logic [3:0]           SETTLE_LAST = 4'(SETTLE - 2);
  // The CAPTURE cycle itself is the last settle cycle, so SETTLE=1 skips the SETTLE state.
  localparam cap_state_t           SETTLE_ENTRY = (SETTLE > 1) ? CAP_SETTLE : CAP_CAPTURE;

  cap_state_t             cap_state;
  logic [ROW_IDX_W-1:0]   cap_row;
  logic                   cap_sel;
  logic [3:0]             settle_cnt;
  logic [TILE_IDX_W-1:0]  tile_y_q;
  logic [ROW_IDX_W-1:0]   next_row;

  logic                   str_sel;
  logic [ROW_IDX_W-1:0]   str_row;
  logic [ROW_IDX_W-1:0]   col;

  logic [1:0]             full;
  logic                   cap_we;
  logic                   accept;
  logic                   xfer;
  logic                   row_end;
  logic                   tile_end;

  // Handshake and capture-enable decode.
  always_comb begin
    accept   = start && !busy;
    cap_we   = ((cap_state == CAP_CAPTURE) || (cap_state == CAP_WAITBUF)) && !full[cap_sel];
    next_row = cap_row + 1'b1;
    xfer     = out_valid && out_ready;
    row_end  = xfer && (col == ROW_LAST);
    tile_end = row_end && (str_row == ROW_LAST);
  end

  // Capture engine: present row coordinates, wait for settle, write lanes when a buffer is free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_state  <= CAP_IDLE;
      cap_row    <= '0;
      cap_sel    <= 1'b0;
      settle_cnt <= '0;
      tile_y_q   <= '0;
      x_ps       <= '0;
      y_ps       <= '0;
    end else begin
      case (cap_state)
        CAP_IDLE: begin
          if (accept) begin
            tile_y_q   <= tile_y;
            cap_row    <= '0;
            cap_sel    <= 1'b0;
            settle_cnt <= '0;
            x_ps       <= {tile_x, 5'd0};
            y_ps       <= {tile_y, 5'd0};
            cap_state  <= SETTLE_ENTRY;
          end
        end
        CAP_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            cap_state <= CAP_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        CAP_CAPTURE, CAP_WAITBUF: begin
          if (!full[cap_sel]) begin
            cap_sel <= ~cap_sel;
            if (cap_row == ROW_LAST) begin
              cap_state <= CAP_IDLE;
            end else begin
              cap_row    <= next_row;
              y_ps       <= {tile_y_q, 5'd0} + {6'd0, next_row};
              settle_cnt <= '0;
              cap_state  <= SETTLE_ENTRY;
            end
          end else begin
            cap_state <= CAP_WAITBUF;
          end
        end
        default: cap_state <= CAP_IDLE;
      endcase
    end
  end

  // Stream engine: walk columns of the current buffer, release it after column 31.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      str_sel <= 1'b0;
      str_row <= '0;
      col     <= '0;
    end else if (xfer) begin
      if (col == ROW_LAST) begin
        str_sel <= ~str_sel;
        str_row <= str_row + 1'b1;
        col     <= '0;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Tile status: busy from accepted start until the final transfer, done one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= tile_end;
      if (accept) begin
        busy <= 1'b1;
      end else if (tile_end) begin
        busy <= 1'b0;
      end
    end
  end

  tile_row_buf u_row_buf (
    .clock   (clock),
    .reset   (reset),
    .wr_sel  (cap_sel),
    .wr_en   (cap_we),
    .wr_data (lanes_in),
    .rd_sel  (str_sel),
    .rd_col  (col),
    .rd_data (out_data),
    .free    (row_end),
    .full    (full)
  );

  // Stream side outputs taken straight from registered state.
  always_comb begin
    out_valid = full[str_sel];
    out_x     = col;
    out_y     = str_row;
    out_last  = out_valid && (col == ROW_LAST) && (str_row == ROW_LAST);
  end

endmodule

// File: tb/tb_tile_row_stepper.sv
// Directed bench for tile_row_stepper; interpolator lanes modelled as y_ps*1000+lane.
module tb_tile_row_stepper;

  localparam int unsigned SETTLE = 2;

  logic          clock;
  logic          reset;
  logic          start;
  logic [5:0]    tile_x;
  logic [5:0]    tile_y;
  logic [10:0]   x_ps;
  logic [10:0]   y_ps;
  logic [1023:0] lanes_in;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [4:0]    out_x;
  logic [4:0]    out_y;
  logic          out_last;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  tile_row_stepper #(.SETTLE(SETTLE)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .tile_x    (tile_x),
    .tile_y    (tile_y),
    .x_ps      (x_ps),
    .y_ps      (y_ps),
    .lanes_in  (lanes_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Interpolator stand-in: lane i carries y_ps*1000 + i.
  always_comb begin
    lanes_in = '0;
    for (int i = 0; i < 32; i++) begin
      lanes_in[32*i +: 32] = 32'(y_ps) * 32'd1000 + 32'(i);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: ready high; 1: random ready; 2: 100-cycle stall after first valid;
  // 3: ready high with a start pulse injected mid-tile.
  task automatic run_tile(input logic [5:0] tx, input logic [5:0] ty, input int mode);
    int cyc;
    int pix;
    int first_valid;
    int ndone;
    logic prev_stall;
    logic [31:0] exp_d;
    @(negedge clock);
    tile_x    = tx;
    tile_y    = ty;
    start     = 1'b1;
    out_ready = 1'b1;
    pix = 0; first_valid = -1; ndone = 0; prev_stall = 1'b0;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    check("busy_rise", 32'(busy), 32'd1);
    check("x_ps_row0", 32'(x_ps), 32'(tx) * 32);
    check("y_ps_row0", 32'(y_ps), 32'(ty) * 32);
    while (ndone == 0 && cyc < 6000) begin
      if (out_valid && first_valid < 0) begin
        first_valid = cyc;
        check("first_valid_cycle", 32'(cyc), 32'(SETTLE + 1));
      end
      case (mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = !(first_valid >= 0 && cyc < first_valid + 100);
        default: out_ready = 1'b1;
      endcase
      if (mode == 2 && first_valid >= 0 && cyc == first_valid + 99) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, 32'(ty) * 32 * 1000);
        check("stall_x", 32'(out_x), 32'd0);
        check("stall_y", 32'(out_y), 32'd0);
        check("stall_y_ps_row2", 32'(y_ps), 32'(ty) * 32 + 2);
      end
      if (prev_stall) check("valid_held", 32'(out_valid), 32'd1);
      if (mode == 3 && cyc == 500) begin
        start  = 1'b1;
        tile_x = tx ^ 6'h15;
        tile_y = ty ^ 6'h2a;
      end
      if (mode == 3 && cyc == 501) start = 1'b0;
      if (mode == 3 && cyc == 505) begin
        check("midstart_x_ps", 32'(x_ps), 32'(tx) * 32);
        check("midstart_busy", 32'(busy), 32'd1);
      end
      if (out_valid && out_ready) begin
        exp_d = 32'((32'(ty) * 32 + 32'(pix / 32)) * 1000 + 32'(pix % 32));
        check("pix_data", out_data, exp_d);
        check("pix_x", 32'(out_x), 32'(pix % 32));
        check("pix_y", 32'(out_y), 32'(pix / 32));
        check("pix_last", 32'(out_last), (pix == 1023) ? 32'd1 : 32'd0);
        if (mode == 0 && pix == 1023) check("last_xfer_cycle", 32'(cyc), 32'(SETTLE + 1024));
        pix++;
      end
      prev_stall = out_valid && !out_ready;
      @(negedge clock);
      cyc++;
      if (done) begin
        ndone++;
        check("pixel_count", 32'(pix), 32'd1024);
        check("busy_fall", 32'(busy), 32'd0);
        check("y_ps_final", 32'(y_ps), 32'(ty) * 32 + 31);
        check("x_ps_final", 32'(x_ps), 32'(tx) * 32);
        if (mode == 0 || mode == 3) check("done_cycle", 32'(cyc), 32'(SETTLE + 1025));
      end
    end
    if (ndone == 0) check("done_timeout", 32'd0, 32'd1);
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("done_once", 32'(ndone), 32'd1);
  endtask

  initial begin
    int found;
    int ndone;
    reset     = 1'b1;
    start     = 1'b0;
    tile_x    = '0;
    tile_y    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_x_ps", 32'(x_ps), 32'd0);
    check("rst_y_ps", 32'(y_ps), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    run_tile(6'd3, 6'd5, 0);
    run_tile(6'd3, 6'd5, 2);
    run_tile(6'd12, 6'd40, 1);
    run_tile(6'd3, 6'd5, 3);

    // Reset in the middle of a tile at pixel (10,4).
    @(negedge clock);
    tile_x = 6'd2; tile_y = 6'd1; start = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 500 && found == 0; c++) begin
      if (out_valid && out_x == 5'd10 && out_y == 5'd4) found = 1;
      else @(negedge clock);
    end
    check("reach_pixel_10_4", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_x_ps", 32'(x_ps), 32'd0);
    check("mid_rst_y_ps", 32'(y_ps), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_x", 32'(out_x), 32'd0);
    check("mid_rst_y", 32'(out_y), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    repeat (60) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("no_done_after_reset", 32'(ndone), 32'd0);
    check("idle_after_reset", 32'(out_valid), 32'd0);

    run_tile(6'd3, 6'd5, 0);
    run_tile(6'd63, 6'd63, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tile_row_stepper.md
# tile_row_stepper

Sequencer that drives the per-tile pixel coordinates into the PVR plane interpolator and streams the resulting per-pixel values out one at a time. For a 32x32 tile it steps `y_ps` through the 32 rows with `x_ps` fixed at the tile origin. After a settle delay it captures the interpolator's 32 parallel lane outputs into a ping-pong row buffer. It then emits them in raster order over a valid/ready stream toward the depth/shading stage.

## Interface

- `SETTLE`, default 2: cycles `y_ps` is held stable before lanes are captured; legal range 1-15.
- `clock` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: pulse that begins a tile; sampled only while `busy`=0.
- `tile_x` in 6: tile column in 32-px units; sampled on `start`.
- `tile_y` in 6: tile row in 32-px units; sampled on `start`.
- `x_ps` out 11: pixel X to the interpolator, = {tile_x,5'd0}.
- `y_ps` out 11: pixel Y to the interpolator, = {tile_y,5'd0}+cap_row.
- `lanes_in` in 1024: interpolator lanes 0..31 packed; lane i is [32i+31:32i], signed.
- `out_valid` out 1: stream valid.
- `out_ready` in 1: stream ready.
- `out_data` out 32: interpolated value.
- `out_x` out 5: column within tile.
- `out_y` out 5: row within tile.
- `out_last` out 1: asserted with pixel (31,31).
- `busy` out 1: a tile is in progress.
- `done` out 1: one-cycle pulse after the final transfer.

## Operation

- Two independent engines share two row buffers, A and B. Each buffer has a `full` flag.
- **Capture FSM**
  - States: IDLE, SETTLE, CAPTURE, WAITBUF.
  - IDLE: on `start` (with `busy`=0), latch tile coordinates, set cap_row=0 and cap_sel=A, then go to SETTLE.
  - SETTLE: hold `x_ps`/`y_ps` for `SETTLE` cycles, then go to CAPTURE.
  - CAPTURE: if buf[cap_sel] is empty, write all 32 lanes, set full, and toggle cap_sel. If cap_row=31, return to IDLE. Otherwise increment cap_row (updating `y_ps`) and go to SETTLE.
  - If buf[cap_sel] is full, go to WAITBUF. Stay in WAITBUF holding `y_ps` until the buffer is empty, then capture.
- **Stream FSM**
  - Tracks str_sel, str_row and col.
  - `out_valid`=full[str_sel].
  - `out_data`=lane col of buf[str_sel]; `out_x`=col; `out_y`=str_row.
  - A transfer happens on `out_valid`&`out_ready`; each transfer increments col.
  - On the transfer at col=31: clear full[str_sel], toggle str_sel, increment str_row, and set col=0.
- **Simultaneous events**
  - A full flag cleared by the stream engine becomes visible to the capture engine the next cycle; no same-cycle reuse.
  - Capturing into one buffer while the other is freed is legal in the same cycle.
- `busy` rises the cycle after accepted `start`. It falls with `done`, the cycle after the (31,31) transfer.
- `start` while `busy`=1 is ignored.
- No arithmetic beyond counters. `y_ps` add is 11-bit unsigned; tile_y=63, row 31 gives 2047, with no wrap possible.
- Reset, including mid-tile: both FSMs return to IDLE, full flags clear, the partial tile is discarded, and no `done` is issued.
- Reset values: all outputs 0 (`x_ps`, `y_ps`, `out_*`, `busy`, `done`).

## Timing

- `start` is accepted at cycle 0.
- Cycle 1: `x_ps`/`y_ps` show row 0.
- Capture edge at the end of cycle `SETTLE`.
- `out_valid` first rises at cycle `SETTLE`+1.
- With `out_ready` held high: one pixel per cycle. Capture of each row (`SETTLE`+1 cycles) hides under the 32-cycle stream, so there are no bubbles after the first row.
  - Last transfer at cycle `SETTLE`+1024.
  - `done` at `SETTLE`+1025.
- `out_data`, `out_x`, `out_y` and `out_last` must stay stable while `out_valid`&!`out_ready`.
- `out_valid` never drops without a transfer.

## Structure

- Shared package/include `pvr_tile_pkg` holds:
  - TILE_DIM=32, LANE_W=32, COORD_W=11, TILE_IDX_W=6;
  - capture FSM state encodings.
- One sub-module, `tile_row_buf`: a two-entry ×1024-bit ping-pong buffer.
  - Write port: sel, we, 1024-bit data.
  - Read port: sel, col, 32-bit data.
  - Owns the full flags: set on write, clear on a free pulse.

## Test plan

- Reset, then `start` with tile_x=3, tile_y=5, `SETTLE`=2, `out_ready`=1, lanes = 1000·row+col driven from `y_ps`. Expect:
  - `x_ps`=96 throughout, `y_ps` 160..191;
  - 1024 in-order pixels, first `out_valid` at cycle 3;
  - `out_last` on (31,31), `done` at cycle 1027.
- `out_ready`=0 for 100 cycles after the first valid. Expect:
  - (0,0) held stable;
  - capture stalls in WAITBUF with `y_ps`=row 2 after rows 0 and 1 fill both buffers;
  - resumes with no lost or duplicated pixels.
- Random `out_ready` (50%): the scoreboard matches all 1024 values and coordinates, and `done` fires exactly once.
- `start` pulsed mid-tile: ignored, and tile coordinates are unchanged.
- `reset` asserted at pixel (10,4): all outputs go to 0 asynchronously and no `done` is issued. A new `start` then produces a complete correct tile.
- Boundary case: tile_x=63, tile_y=63 gives `x_ps`=2016 and `y_ps` up to 2047.
